// File: rtl/cpu_pkg.sv
// Shared load/store encodings: access size codes and their byte counts.
package cpu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Field width in bytes for a size code (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ext_field.sv
// Combinational field extraction from a memory word with zero/sign extension.
module ext_field
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0,
    localparam int unsigned NB        = DATA_W / 8,
    localparam int unsigned OFS_W     = $clog2(NB)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] ext,
    output logic              err
);

    logic [3:0]        sb;
    logic [3:0]        ofs_x;
    logic [3:0]        lane;
    logic [6:0]        fbits;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        sb      = size_bytes(size);
        ofs_x   = 4'(ofs);
        err     = (sb > 4'(NB)) || ((ofs_x & (sb - 4'd1)) != 4'd0);
        lane    = BIG_ENDIAN ? (4'(NB) - ofs_x - sb) : ofs_x;
        fbits   = {sb, 3'b000};
        shifted = raw >> {lane, 3'b000};
        mask    = '1;
        sign    = 1'b0;
        ext     = '0;
        if (!err) begin
            mask = {DATA_W{1'b1}} >> (7'(DATA_W) - fbits);
            // mask ^ (mask >> 1) isolates the field MSB without a variable index
            sign = (|(shifted & (mask ^ (mask >> 1)))) & ~uns;
            ext  = (shifted & mask) | (sign ? ~mask : '0);
        end
    end

endmodule

// File: rtl/load_ext_pipe.sv
// Two-stage elastic load-extension pipeline: S1 holds the request, S2 the result.
module load_ext_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0,
    localparam int unsigned NB        = DATA_W / 8,
    localparam int unsigned OFS_W     = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFS_W-1:0]  in_ofs,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [OFS_W-1:0]  s1_ofs;
    logic [1:0]        s1_size;
    logic              s1_uns;

    logic              s1_advance;
    logic              s2_advance;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_advance;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_data <= in_data;
            s1_ofs  <= in_ofs;
            s1_size <= in_size;
            s1_uns  <= in_unsigned;
        end
    end

    ext_field #(
        .DATA_W    (DATA_W),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_ext_field (
        .raw (s1_data),
        .ofs (s1_ofs),
        .size(s1_size),
        .uns (s1_uns),
        .ext (ext_data),
        .err (ext_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= ext_data;
                out_err  <= ext_err;
            end
        end
    end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed bench for load_ext_pipe: 32-bit LE/BE and 64-bit LE instances.
module tb_load_ext_pipe;

    logic        clk;
    logic        rst_n;

    // Shared request bus for the two 32-bit instances
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_ofs;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_ready;

    logic        le_in_ready, le_out_valid, le_out_err;
    logic [31:0] le_out_data;
    logic        be_in_ready, be_out_valid, be_out_err;
    logic [31:0] be_out_data;

    logic        w_in_valid;
    logic [63:0] w_in_data;
    logic [2:0]  w_in_ofs;
    logic [1:0]  w_in_size;
    logic        w_in_unsigned;
    logic        w_out_ready;
    logic        w_in_ready, w_out_valid, w_out_err;
    logic [63:0] w_out_data;

    int checks;
    int errors;

    load_ext_pipe #(.DATA_W(32), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(le_in_ready), .in_data(in_data), .in_ofs(in_ofs),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(le_out_valid), .out_ready(out_ready), .out_data(le_out_data),
        .out_err(le_out_err)
    );

    load_ext_pipe #(.DATA_W(32), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(be_in_ready), .in_data(in_data), .in_ofs(in_ofs),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(be_out_valid), .out_ready(out_ready), .out_data(be_out_data),
        .out_err(be_out_err)
    );

    load_ext_pipe #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_ofs(w_in_ofs),
        .in_size(w_in_size), .in_unsigned(w_in_unsigned),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_err(w_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request to both 32-bit instances; returns with the result visible.
    task automatic req32(input logic [31:0] d, input logic [1:0] o, input logic [1:0] s,
                         input logic u, input string tag);
        in_data = d; in_ofs = o; in_size = s; in_unsigned = u; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, 64'(le_out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic req64(input logic [63:0] d, input logic [2:0] o, input logic [1:0] s,
                         input logic u, input string tag);
        w_in_data = d; w_in_ofs = o; w_in_size = s; w_in_unsigned = u; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check({tag, "_early"}, 64'(w_out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    // Stream vectors: data 0x7F8001FE, ofs = i%4, size = byte, unsigned for i >= 4
    logic [31:0] stream_exp [8] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FF80, 32'h0000_007F,
                                    32'h0000_00FE, 32'h0000_0001, 32'h0000_0080, 32'h0000_007F};
    logic [3:0]  rdy_pat = 4'b1001;

    initial begin
        int sent, recv;
        logic m_s1, m_s2, exp_rdy, held, s2_adv;
        logic [31:0] held_data;

        checks = 0; errors = 0;
        in_valid = 1'b0; in_data = '0; in_ofs = '0; in_size = '0; in_unsigned = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_ofs = '0; w_in_size = '0; w_in_unsigned = 1'b0;
        out_ready = 1'b1; w_out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(le_out_valid), 64'd0);
        check("rst_out_data", 64'(le_out_data), 64'd0);
        check("rst_out_err", 64'(le_out_err), 64'd0);
        check("rst_in_ready", 64'(le_in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        req32(32'h8765_43F0, 2'd0, 2'd0, 1'b0, "b_signed");
        check("b_signed_valid", 64'(le_out_valid), 64'd1);
        check("b_signed_data", 64'(le_out_data), 64'h0000_0000_FFFF_FFF0);
        check("b_signed_err", 64'(le_out_err), 64'd0);
        check("b_signed_be", 64'(be_out_data), 64'h0000_0000_FFFF_FF87);

        req32(32'h8765_43F0, 2'd0, 2'd0, 1'b1, "b_uns");
        check("b_uns_data", 64'(le_out_data), 64'h0000_0000_0000_00F0);
        check("b_uns_be", 64'(be_out_data), 64'h0000_0000_0000_0087);

        req32(32'h8001_1234, 2'd2, 2'd1, 1'b0, "h_signed");
        check("h_signed_le", 64'(le_out_data), 64'h0000_0000_FFFF_8001);
        check("h_signed_be", 64'(be_out_data), 64'h0000_0000_0000_1234);
        check("h_signed_err", 64'(be_out_err), 64'd0);

        req32(32'h8001_1234, 2'd1, 2'd1, 1'b0, "h_misal");
        check("h_misal_err", 64'(le_out_err), 64'd1);
        check("h_misal_data", 64'(le_out_data), 64'd0);
        check("h_misal_be_err", 64'(be_out_err), 64'd1);

        req32(32'h8001_1234, 2'd0, 2'd3, 1'b0, "d_on32");
        check("d_on32_err", 64'(le_out_err), 64'd1);
        check("d_on32_data", 64'(le_out_data), 64'd0);
        check("d_on32_valid", 64'(le_out_valid), 64'd1);

        req32(32'h8001_1234, 2'd0, 2'd2, 1'b1, "w_pass");
        check("w_pass_le", 64'(le_out_data), 64'h0000_0000_8001_1234);
        check("w_pass_be", 64'(be_out_data), 64'h0000_0000_8001_1234);
        check("w_pass_err", 64'(le_out_err), 64'd0);

        req64(64'h0000_0000_8000_0000, 3'd0, 2'd2, 1'b0, "w64_signed");
        check("w64_signed_data", w_out_data, 64'hFFFF_FFFF_8000_0000);
        check("w64_signed_err", 64'(w_out_err), 64'd0);
        req64(64'h0000_0000_8000_0000, 3'd0, 2'd2, 1'b1, "w64_uns");
        check("w64_uns_data", w_out_data, 64'h0000_0000_8000_0000);
        req64(64'h1234_5678_0000_0000, 3'd4, 2'd2, 1'b0, "w64_hi");
        check("w64_hi_data", w_out_data, 64'h0000_0000_1234_5678);
        req64(64'hFEDC_BA98_7654_3210, 3'd0, 2'd3, 1'b0, "w64_d");
        check("w64_d_data", w_out_data, 64'hFEDC_BA98_7654_3210);
        check("w64_d_err", 64'(w_out_err), 64'd0);
        req64(64'hFEDC_BA98_7654_3210, 3'd4, 2'd3, 1'b0, "w64_dmis");
        check("w64_dmis_err", 64'(w_out_err), 64'd1);
        check("w64_dmis_data", w_out_data, 64'd0);

        // Back-to-back stream with stalling consumer
        @(posedge clk); #1;
        sent = 0; recv = 0; m_s1 = 1'b0; m_s2 = 1'b0; held = 1'b0; held_data = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            out_ready   = rdy_pat[3 - (cyc % 4)];
            in_valid    = (sent < 8);
            in_data     = 32'h7F80_01FE;
            in_ofs      = 2'(sent % 4);
            in_size     = 2'd0;
            in_unsigned = (sent >= 4);
            @(negedge clk);
            s2_adv  = !m_s2 || out_ready;
            exp_rdy = !m_s1 || s2_adv;
            check("stream_in_ready", 64'(le_in_ready), 64'(exp_rdy));
            check("stream_out_valid", 64'(le_out_valid), 64'(m_s2));
            if (held && le_out_valid)
                check("stream_stable", 64'(le_out_data), 64'(held_data));
            if (le_out_valid && out_ready) begin
                check("stream_data", 64'(le_out_data), 64'(stream_exp[recv % 8]));
                recv++;
            end
            held      = le_out_valid && !out_ready;
            held_data = le_out_data;
            if (s2_adv) m_s2 = m_s1;
            if (exp_rdy) m_s1 = in_valid;
            if (in_valid && exp_rdy) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(recv), 64'd8);

        // Fill both stages with the consumer stalled, then reset mid-cycle
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_data = 32'h8765_43F0; in_ofs = 2'd0; in_size = 2'd0; in_unsigned = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", 64'(le_in_ready), 64'd0);
        check("full_out_data", 64'(le_out_data), 64'h0000_0000_FFFF_FFF0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(le_out_valid), 64'd0);
        check("midrst_out_data", 64'(le_out_data), 64'd0);
        check("midrst_in_ready", 64'(le_in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("postrst_quiet", 64'(le_out_valid), 64'd0);
        end
        req32(32'h8001_1234, 2'd2, 2'd1, 1'b1, "postrst");
        check("postrst_data", 64'(le_out_data), 64'h0000_0000_0000_8001);
        check("postrst_valid", 64'(le_out_valid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_ext_pipe.md
LOAD_EXT_PIPE -- requirements
Module: load_ext_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 0, meaning byte-lane order: 0 is little-endian, 1 is big-endian.
REQ-003 The block SHALL have derived localparams NB = DATA_W/8 and OFS_W = log2(NB).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: the raw memory word.
REQ-009 The block SHALL have port in_ofs, input, OFS_W bits: byte offset of the field within in_data.
REQ-010 The block SHALL have port in_size, input, 2 bits: field size, 0=byte, 1=half, 2=word, 3=dword.
REQ-011 The block SHALL have port in_unsigned, input, 1 bit: 1 = zero-extend, 0 = sign-extend.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port out_data, output, DATA_W bits: the extended result.
REQ-015 The block SHALL have port out_err, output, 1 bit: misaligned access or illegal size.

Function
REQ-016 A transfer SHALL occur on a rising edge when valid and ready are both 1, on either side.
REQ-017 The block SHALL be a 2-stage elastic pipeline: S1 registers the request, S2 computes and registers the result.
REQ-018 Latency SHALL be 2 cycles from input acceptance to out_valid when out_ready stays high.
REQ-019 Throughput SHALL be one transfer per cycle under continuous valid/ready.
REQ-020 Each stage SHALL advance when it is empty or when its content is being taken by the next stage.
REQ-021 in_ready SHALL equal !s1_valid || s1_advance.
REQ-022 With out_ready low, out_valid, out_data and out_err SHALL hold stable, and no transfer SHALL be lost or duplicated.
REQ-023 Field byte count SHALL be SB = 1 << in_size.
REQ-024 The field lane SHALL be byte ofs when little-endian, and byte NB-ofs-SB when BIG_ENDIAN=1.
REQ-025 The result SHALL be the extracted SB*8-bit field, extended to DATA_W with zeros when in_unsigned=1, otherwise with the field MSB.
REQ-026 in_size=2 with DATA_W=32 SHALL pass the word unchanged; in_unsigned SHALL be ignored.
REQ-027 out_err SHALL be 1 when in_ofs mod SB != 0, or when SB > NB; out_data SHALL then be 0.
REQ-028 An erroring request SHALL still occupy one pipeline slot and complete normally.
REQ-029 When S2 drains and S1 refills in the same edge, the pipeline SHALL keep data ordering intact.

Reset
REQ-030 While rst_n=0, the block SHALL force s1_valid=0, out_valid=0, out_data=0 and out_err=0 immediately, without waiting for clk.
REQ-031 While rst_n=0, in_ready SHALL be 1.
REQ-032 Data registers other than out_data need not be reset.
REQ-033 Reset mid-operation SHALL discard in-flight requests, with no output after deassertion until a new input transfer.
REQ-034 Deassertion SHALL be synchronised externally; the block imposes no extra recovery cycles.

Structure
REQ-035 The size encodings (SZ_B, SZ_H, SZ_W, SZ_D) SHALL live in shared package cpu_pkg, reused by the load/store unit.
REQ-036 Extraction and extension SHALL live in one combinational sub-module, ext_field (inputs data, ofs, size, unsigned; outputs data, err).
REQ-037 ext_field SHALL be instantiated between S1 and S2; load_ext_pipe itself holds only the pipeline registers and handshake.

Verification
REQ-038 The bench SHALL cover: DATA_W=32, LE, data 0x8765_43F0, ofs=0, size=0, signed -> 0xFFFF_FFF0 two cycles later, err=0; same with unsigned -> 0x0000_00F0.
REQ-039 The bench SHALL cover: DATA_W=32, LE, data 0x8001_1234, ofs=2, size=1, signed -> 0xFFFF_8001; BIG_ENDIAN=1 same request -> 0x0000_1234.
REQ-040 The bench SHALL cover: DATA_W=32, ofs=1, size=1 -> out_err=1, out_data=0; size=3 -> out_err=1.
REQ-041 The bench SHALL cover: DATA_W=64, LE, data 0x0000_0000_8000_0000, ofs=0, size=2, signed -> 0xFFFF_FFFF_8000_0000.
REQ-042 The bench SHALL cover: 8 back-to-back requests with out_ready toggling 1,0,0,1,... -> all 8 results arrive in order, no loss, outputs stable while stalled, in_ready=0 only when both stages are full and stalled.
REQ-043 The bench SHALL cover: rst_n asserted with both stages full -> out_valid=0 immediately; after release, no output until a new request.
